// File: rtl/alu_ctrl_pkg.sv
// Shared types and defaults for the chunked add/subtract overflow controller.
package alu_ctrl_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    CHECK,
    TRAP,
    DONE
  } state_e;

endpackage

// File: rtl/alu_chunk_add.sv
// CHUNK-bit combinational slice adder; also reports the carry into its MSB so
// the controller can form signed overflow on the final slice.
module alu_chunk_add
  import alu_ctrl_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum  = full[CHUNK-1:0];
  assign cout = full[CHUNK];
  // sum MSB = a ^ b ^ carry-in, so the carry into the MSB can be recovered.
  assign cmsb = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/alu_overflow_ctrl.sv
// Multi-cycle signed add/subtract with overflow flags and an optional trap
// handshake, enabled by defining OVF_TRAP_EN.
module alu_overflow_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_sticky,
  input  logic             trap_ack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             ovf_sticky,
  output logic             trap_req
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  state_e           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic             cmsb_r;
  logic [CW-1:0]    cnt;

  logic [CHUNK-1:0] sl_sum;
  logic             sl_cout;
  logic             sl_cmsb;
  logic             ovf_now;

  alu_chunk_add #(.CHUNK(CHUNK)) u_slice (
    .a    (a_r[cnt*CHUNK +: CHUNK]),
    .b    (b_r[cnt*CHUNK +: CHUNK]),
    .cin  (carry),
    .sum  (sl_sum),
    .cout (sl_cout),
    .cmsb (sl_cmsb)
  );

  // After the last slice, carry holds the MSB carry-out.
  assign ovf_now = cmsb_r ^ carry;

`ifndef OVF_TRAP_EN
  logic unused_trap_ack;
  assign unused_trap_ack = trap_ack;
  assign trap_req = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      sum_r      <= '0;
      carry      <= 1'b0;
      cmsb_r     <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
`ifdef OVF_TRAP_EN
      trap_req   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1, so the inversion and carry-in are set here.
            a_r   <= a;
            b_r   <= (op_sub == OP_SUB) ? ~b : b;
            carry <= op_sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          sum_r[cnt*CHUNK +: CHUNK] <= sl_sum;
          carry  <= sl_cout;
          cmsb_r <= sl_cmsb;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) state <= CHECK;
        end
        CHECK: begin
`ifdef OVF_TRAP_EN
          if (ovf_now) begin
            trap_req <= 1'b1;
            state    <= TRAP;
          end else begin
            done   <= 1'b1;
            result <= sum_r;
            ovf    <= ovf_now;
            state  <= DONE;
          end
`else
          done   <= 1'b1;
          result <= sum_r;
          ovf    <= ovf_now;
          state  <= DONE;
`endif
        end
`ifdef OVF_TRAP_EN
        TRAP: begin
          if (trap_ack) begin
            trap_req <= 1'b0;
            done     <= 1'b1;
            result   <= sum_r;
            ovf      <= ovf_now;
            state    <= DONE;
          end
        end
`endif
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase

      // A fresh overflow beats a simultaneous clear request.
      if (state == CHECK && ovf_now) ovf_sticky <= 1'b1;
      else if (clr_sticky)           ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_overflow_ctrl.sv
// Scoreboard testbench for alu_overflow_ctrl; adapts to builds with OVF_TRAP_EN.
module tb_alu_overflow_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op_sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        clr_sticky = 1'b0;
  logic        trap_ack = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        ovf;
  logic        ovf_sticky;
  logic        trap_req;

`ifdef OVF_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  typedef struct {
    logic [15:0] res;
    logic        v;
    logic        sticky;
    int          expCyc;
  } exp_t;

  exp_t q[$];
  exp_t monE;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic stickyModel = 1'b0;

  always #5 clk = ~clk;

  alu_overflow_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_sub     (op_sub),
    .a          (a),
    .b          (b),
    .clr_sticky (clr_sticky),
    .trap_ack   (trap_ack),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .ovf        (ovf),
    .ovf_sticky (ovf_sticky),
    .trap_req   (trap_req)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Signed arithmetic on plain ints: anything outside 16-bit range overflowed.
  function automatic void refModel(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                                   output logic [15:0] r, output logic v);
    int sa;
    int sb;
    int full;
    sa = $signed(ia);
    sb = $signed(ib);
    full = isub ? (sa - sb) : (sa + sb);
    r = full[15:0];
    v = (full > 32767) || (full < -32768);
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no completion (cycle %0d)", cyc);
      end else begin
        monE = q.pop_front();
        checkOutput("result", result, monE.res);
        checkOutput("ovf", ovf, monE.v);
        checkOutput("ovf_sticky", ovf_sticky, monE.sticky);
        checkOutput("trap_req_at_done", trap_req, 0);
        if (monE.expCyc >= 0) checkOutput("latency", cyc, monE.expCyc);
      end
    end
  end

  task automatic waitDone();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    checkOutput("queue_drained", q.size(), 0);
    q.delete();
  endtask

  task automatic applyStimulus(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                               input bit clrInCheck, input bit poke, input int ackDelay);
    logic [15:0] r;
    logic        v;
    exp_t        e;
    @(posedge clk); #1;
    a = ia; b = ib; op_sub = isub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    refModel(ia, ib, isub, r, v);
    if (v) stickyModel = 1'b1;
    else if (clrInCheck) stickyModel = 1'b0;
    e.res = r;
    e.v = v;
    e.sticky = stickyModel;
    e.expCyc = (v && TRAP_ON) ? -1 : cyc + 6;
    q.push_back(e);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checkOutput("busy", busy, 1);
      checkOutput("trap_req_low", trap_req, 0);
      if (poke && c == 2) begin
        start = 1'b1; a = ~ia; b = ib ^ 16'h5a5a; op_sub = ~isub; trap_ack = 1'b1;
      end
      if (poke && c == 3) begin
        start = 1'b0; trap_ack = 1'b0;
      end
      if (clrInCheck && c == 5) clr_sticky = 1'b1;
    end
    @(negedge clk);
    clr_sticky = 1'b0;
    if (v && TRAP_ON) begin
      checkOutput("trap_req_hold", trap_req, 1);
      repeat (ackDelay) begin
        @(negedge clk);
        checkOutput("trap_req_hold", trap_req, 1);
      end
      trap_ack = 1'b1;
      @(negedge clk);
      trap_ack = 1'b0;
      checkOutput("done_after_ack", done, 1);
    end
    waitDone();
  endtask

  task automatic pulseClear();
    @(posedge clk); #1;
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    stickyModel = 1'b0;
    @(negedge clk);
    checkOutput("sticky_cleared", ovf_sticky, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;

    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_sticky", ovf_sticky, 0);
    checkOutput("rst_trap_req", trap_req, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 3);
    applyStimulus(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 1);
    applyStimulus(16'h0005, 16'h0003, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1);
    pulseClear();
    applyStimulus(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1, 0);
    applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 2);

    @(posedge clk); #1;
    a = 16'h1234; b = 16'h4321; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_result", result, 0);
    checkOutput("abort_ovf", ovf, 0);
    checkOutput("abort_sticky", ovf_sticky, 0);
    checkOutput("abort_trap_req", trap_req, 0);
    stickyModel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 3))
        0: ra = 16'h7FF0 | {12'h000, ra[3:0]};
        1: ra = 16'h8000 | {12'h000, ra[3:0]};
        default: ;
      endcase
      if ($urandom_range(0, 2) == 0) rb = {12'h000, rb[3:0]};
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) pulseClear();
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_overflow_ctrl.md
ALU_OVERFLOW_CTRL -- requirements
Module: alu_overflow_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter CHUNK, default 4, bits added per cycle; WIDTH SHALL be a multiple of CHUNK.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request one operation; sampled only in IDLE.
REQ-006 op_sub  input  1  0 = a+b, 1 = a-b; latched with start.
REQ-007 a, b  input  WIDTH  signed two's-complement operands; latched with start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 result  output  WIDTH  wrapped sum/difference; held until next completion.
REQ-011 ovf  output  1  signed overflow of the last completed operation; held with result.
REQ-012 ovf_sticky  output  1  set by any overflow; cleared only by clr_sticky or rst.
REQ-013 clr_sticky  input  1  clears ovf_sticky.
REQ-014 trap_req  output  1  overflow trap request to the control unit.
REQ-015 trap_ack  input  1  trap acknowledge.

Function
REQ-016 FSM states SHALL be IDLE, CALC, CHECK, TRAP, DONE.
- IDLE -> CALC when start=1: latch a, b, op_sub; clear chunk counter.
- CALC: add one CHUNK slice per cycle, LSB first, carry in a register; WIDTH/CHUNK cycles, then CHECK.
- CHECK: evaluate overflow, one cycle; -> TRAP if overflow and trap enabled, else DONE.
- TRAP: trap_req=1; -> DONE on the cycle trap_ack is sampled high.
- DONE: done=1, result/ovf updated, one cycle; -> IDLE.
REQ-017 Subtraction SHALL use b inverted with an initial carry-in of 1; addition SHALL use a carry-in of 0.
REQ-018 Overflow SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-019 Latency: done SHALL be high exactly WIDTH/CHUNK+2 cycles after the start edge when no trap occurs (6 cycles at defaults).
REQ-020 start while busy SHALL be ignored; no queuing.
REQ-021 result SHALL be written on overflow as well, wrapped modulo 2^WIDTH.
REQ-022 When clr_sticky and a new overflow occur in the same cycle, set SHALL win.
REQ-023 trap_ack outside TRAP SHALL be ignored; trap_req SHALL be held until acknowledged, with no timeout.
REQ-024 start and done SHALL NOT be combinationally related.

Reset
REQ-025 On rst: state IDLE; busy, done, ovf, ovf_sticky and trap_req 0; result 0; latched operands and carry 0.
REQ-026 rst mid-operation or mid-trap SHALL abort the operation with no done pulse; the first start after rst release SHALL be accepted.

Configuration
REQ-027 Macro OVF_TRAP_EN defined: TRAP state and the trap_req/trap_ack handshake are present.
REQ-028 Macro OVF_TRAP_EN undefined: CHECK always goes to DONE; trap_req is tied 0; trap_ack is unused; ovf and ovf_sticky are unchanged.

Structure
REQ-029 Shared package alu_ctrl_pkg SHALL hold the FSM state enum, the op encoding (OP_ADD=0, OP_SUB=1) and the default WIDTH/CHUNK constants.
REQ-030 Sub-module alu_chunk_add SHALL be the CHUNK-bit combinational slice adder, with outputs sum, carry-out and carry-into-MSB.

Verification (WIDTH=16, CHUNK=4)
REQ-031 0x1234+0x1111, op_sub=0 -> result 0x2345, ovf=0, done exactly 6 cycles after start, busy high in the 5 cycles before done.
REQ-032 0x7FFF+0x0001 (trap disabled) -> result 0x8000, ovf=1, ovf_sticky=1, trap_req stays 0.
REQ-033 0x8000-0x0001 -> result 0x7FFF, ovf=1; a following 0x0005-0x0003 -> result 0x0002, ovf=0, ovf_sticky still 1.
REQ-034 OVF_TRAP_EN, 0x7FFF+0x0001, trap_ack held low 3 cycles then high -> trap_req high throughout, done the cycle after trap_ack is sampled high.
REQ-035 rst asserted in the 2nd CALC cycle -> all outputs 0 immediately, no done pulse; a subsequent start of 0x0001+0x0001 -> result 0x0002.
REQ-036 clr_sticky pulsed in the same cycle as an overflowing CHECK -> ovf_sticky=1; start pulsed while busy -> ignored, exactly one done.
